// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hold/flush sequencer for a 5-stage RV32I pipeline. Handles
//               jumps, load-use stalls, multi-cycle ex ops and debug halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MD_TIMEOUT   = 64,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_mem_rd_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_use_i,
    input  logic        id_rs2_use_i,
    input  logic        md_start_i,
    input  logic        md_done_i,
    input  logic        halt_req_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        halt_ack_o,
    output logic        md_timeout_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_FLUSH   = 3'd1,
        ST_MD_WAIT = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [2:0] c_FLUSH_INIT = 3'(FLUSH_CYCLES);
    localparam logic [2:0] c_DRAIN_INIT = 3'(DRAIN_CYCLES);
    localparam logic [9:0] c_TCNT_LAST  = 10'(MD_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [9:0] tcnt_q, tcnt_d;
    logic       halt_ack_q, halt_ack_d;
    logic       md_timeout_q, md_timeout_d;

    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic       w_load_use;
    logic       w_jump_take;

    assign w_rs1_hit   = id_rs1_use_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign w_rs2_hit   = id_rs2_use_i && (id_rs2_addr_i == ex_rd_addr_i);
    assign w_load_use  = ex_mem_rd_i && (ex_rd_addr_i != 5'd0) && (w_rs1_hit || w_rs2_hit);
    // A halted core must not be redirected by whatever sits in ex.
    assign w_jump_take = jump_en_i && (state_q != ST_HALT);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tcnt_d        = tcnt_q;
        md_timeout_d  = md_timeout_q;
        jump_en_o     = 1'b0;
        jump_addr_o   = 32'd0;
        hold_pc_o     = 1'b0;
        hold_if_id_o  = 1'b0;
        hold_id_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;

        if (w_jump_take) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            if (FLUSH_CYCLES > 0) begin
                state_d = ST_FLUSH;
                cnt_d   = c_FLUSH_INIT;
            end else begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (md_start_i) begin
                        // A done in the launch cycle is a zero-cycle op.
                        if (!md_done_i) begin
                            state_d = ST_MD_WAIT;
                            tcnt_d  = 10'd0;
                        end
                    end else if (w_load_use) begin
                        hold_pc_o     = 1'b1;
                        hold_if_id_o  = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else if (halt_req_i) begin
                        state_d = ST_DRAIN;
                        cnt_d   = c_DRAIN_INIT;
                    end
                end

                ST_FLUSH: begin
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    cnt_d         = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end
                end

                ST_MD_WAIT: begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                    hold_id_ex_o = 1'b1;
                    tcnt_d       = tcnt_q + 10'd1;
                    if (md_done_i) begin
                        state_d = ST_RUN;
                    end else if (tcnt_q >= c_TCNT_LAST) begin
                        md_timeout_d = 1'b1;
                        state_d      = ST_RUN;
                    end
                end

                ST_DRAIN: begin
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (!halt_req_i) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                        if (cnt_q <= 3'd1) begin
                            state_d = ST_HALT;
                        end
                    end
                end

                ST_HALT: begin
                    hold_pc_o     = 1'b1;
                    hold_if_id_o  = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (!halt_req_i) begin
                        state_d = ST_RUN;
                    end
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        halt_ack_d = (state_q == ST_HALT) && halt_req_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= 3'd0;
            tcnt_q       <= 10'd0;
            halt_ack_q   <= 1'b0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tcnt_q       <= tcnt_d;
            halt_ack_q   <= halt_ack_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    assign halt_ack_o   = halt_ack_q;
    assign md_timeout_o = md_timeout_q;
    assign state_o      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl (vector table plus
//               hand-written multi-cycle sequences, queue-based scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic        jump_en;
        logic [31:0] jump_addr;
        logic        ex_mem_rd;
        logic [4:0]  ex_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rs1_use;
        logic        rs2_use;
        logic        md_start;
        logic        md_done;
        logic        halt_req;
    } in_t;

    typedef struct packed {
        logic        jump_en;
        logic [31:0] jump_addr;
        logic        hold_pc;
        logic        hold_if_id;
        logic        hold_id_ex;
        logic        flush_if_id;
        logic        flush_id_ex;
        logic        halt_ack;
        logic        md_timeout;
        logic [2:0]  state;
    } out_t;

    typedef struct {
        in_t   i;
        out_t  o;
        string name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en_i, ex_mem_rd_i, id_rs1_use_i, id_rs2_use_i;
    logic        md_start_i, md_done_i, halt_req_i;
    logic [31:0] jump_addr_i;
    logic [4:0]  ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i;
    logic        jump_en_o, hold_pc_o, hold_if_id_o, hold_id_ex_o;
    logic        flush_if_id_o, flush_id_ex_o, halt_ack_o, md_timeout_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  state_o;

    int    n_cmp = 0;
    int    n_err = 0;
    logic  exp_to = 1'b0;
    out_t  exp_q[$];
    string nm_q[$];
    vec_t  vecs[$];

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES (1),
        .MD_TIMEOUT   (64),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .ex_mem_rd_i   (ex_mem_rd_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_use_i  (id_rs1_use_i),
        .id_rs2_use_i  (id_rs2_use_i),
        .md_start_i    (md_start_i),
        .md_done_i     (md_done_i),
        .halt_req_i    (halt_req_i),
        .jump_en_o     (jump_en_o),
        .jump_addr_o   (jump_addr_o),
        .hold_pc_o     (hold_pc_o),
        .hold_if_id_o  (hold_if_id_o),
        .hold_id_ex_o  (hold_id_ex_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .halt_ack_o    (halt_ack_o),
        .md_timeout_o  (md_timeout_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic in_t mk_in(input logic jen, input logic [31:0] addr,
                                  input logic mrd, input logic [4:0] rd,
                                  input logic [4:0] r1, input logic [4:0] r2,
                                  input logic u1, input logic u2,
                                  input logic ms, input logic md, input logic hr);
        in_t v;
        v = '{jen, addr, mrd, rd, r1, r2, u1, u2, ms, md, hr};
        return v;
    endfunction

    function automatic out_t mk_out(input logic jen, input logic [31:0] addr,
                                    input logic hpc, input logic hif, input logic hex,
                                    input logic fif, input logic fex, input logic ack,
                                    input logic to, input logic [2:0] st);
        out_t v;
        v = '{jen, addr, hpc, hif, hex, fif, fex, ack, to, st};
        return v;
    endfunction

    function automatic in_t i_idle();
        return mk_in(0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    endfunction
    function automatic in_t i_jump(input logic [31:0] a);
        return mk_in(1, a, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    endfunction
    function automatic in_t i_halt();
        return mk_in(0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    endfunction
    function automatic in_t i_md(input logic ms, input logic md);
        return mk_in(0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ms, md, 0);
    endfunction
    function automatic out_t o_idle(input logic [2:0] st);
        return mk_out(0, 32'd0, 0, 0, 0, 0, 0, 0, 0, st);
    endfunction
    function automatic out_t o_jump(input logic [31:0] a, input logic [2:0] st);
        return mk_out(1, a, 0, 0, 0, 1, 1, 0, 0, st);
    endfunction
    function automatic out_t o_stall(input logic [2:0] st, input logic ack);
        return mk_out(0, 32'd0, 1, 1, 0, 0, 1, ack, 0, st);
    endfunction

    localparam out_t O_FLUSH = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
    localparam out_t O_MD    = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};

    task automatic add_vec(input in_t vi, input out_t vo, input string nm);
        vec_t v;
        v.i    = vi;
        v.o    = vo;
        v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t vi);
        jump_en_i     = vi.jump_en;
        jump_addr_i   = vi.jump_addr;
        ex_mem_rd_i   = vi.ex_mem_rd;
        ex_rd_addr_i  = vi.ex_rd;
        id_rs1_addr_i = vi.rs1;
        id_rs2_addr_i = vi.rs2;
        id_rs1_use_i  = vi.rs1_use;
        id_rs2_use_i  = vi.rs2_use;
        md_start_i    = vi.md_start;
        md_done_i     = vi.md_done;
        halt_req_i    = vi.halt_req;
    endtask

    task automatic check_one();
        out_t  act;
        out_t  exp;
        string nm;
        act = '{jump_en_o, jump_addr_o, hold_pc_o, hold_if_id_o, hold_id_ex_o,
                flush_if_id_o, flush_id_ex_o, halt_ack_o, md_timeout_o, state_o};
        exp = exp_q.pop_front();
        nm  = nm_q.pop_front();
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got jen=%b addr=%h hold=%b%b%b flush=%b%b ack=%b to=%b st=%0d, want jen=%b addr=%h hold=%b%b%b flush=%b%b ack=%b to=%b st=%0d",
                     nm, $time, act.jump_en, act.jump_addr, act.hold_pc, act.hold_if_id,
                     act.hold_id_ex, act.flush_if_id, act.flush_id_ex, act.halt_ack,
                     act.md_timeout, act.state, exp.jump_en, exp.jump_addr, exp.hold_pc,
                     exp.hold_if_id, exp.hold_id_ex, exp.flush_if_id, exp.flush_id_ex,
                     exp.halt_ack, exp.md_timeout, exp.state);
        end
    endtask

    // Drive one cycle of stimulus, score it mid-cycle, land just after the next edge.
    task automatic step(input in_t vi, input out_t vo, input string nm);
        out_t e;
        drive(vi);
        e            = vo;
        e.md_timeout = vo.md_timeout | exp_to;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    initial begin
        add_vec(i_idle(), o_idle(3'd0), "idle_run");
        add_vec(mk_in(0, 32'hDEADBEEF, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0), o_idle(3'd0), "addr_zero_no_jump");
        add_vec(i_jump(32'h40), o_jump(32'h40, 3'd0), "jump_run");
        add_vec(i_idle(), O_FLUSH, "flush_cycle");
        add_vec(i_idle(), o_idle(3'd0), "flush_done");
        add_vec(mk_in(0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0), o_stall(3'd0, 0), "lu_rs2");
        add_vec(i_idle(), o_idle(3'd0), "lu_clear");
        add_vec(mk_in(0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0), o_idle(3'd0), "lu_rd_zero");
        add_vec(mk_in(0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0), o_idle(3'd0), "lu_rs1_unused");
        add_vec(mk_in(0, 0, 1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, 0), o_stall(3'd0, 0), "lu_rs1");
        add_vec(mk_in(0, 0, 0, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, 0), o_idle(3'd0), "lu_not_load");
        add_vec(mk_in(1, 32'h100, 1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, 0), o_jump(32'h100, 3'd0), "jump_over_lu");
        add_vec(mk_in(0, 0, 1, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0, 0), O_FLUSH, "lu_ignored_in_flush");
        add_vec(i_idle(), o_idle(3'd0), "run_again");
        add_vec(i_jump(32'h200), o_jump(32'h200, 3'd0), "jump_2");
        add_vec(i_jump(32'h204), o_jump(32'h204, 3'd1), "jump_in_flush");
        add_vec(i_idle(), O_FLUSH, "flush_restart");
        add_vec(i_idle(), o_idle(3'd0), "run_3");
        add_vec(mk_in(0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0, 0, 0, 1), o_stall(3'd0, 0), "lu_over_halt");
        add_vec(i_idle(), o_idle(3'd0), "no_drain_after_lu");
        add_vec(i_md(1, 1), o_idle(3'd0), "md_zero_cycle");
        add_vec(i_idle(), o_idle(3'd0), "md_zero_stays_run");

        drive(i_idle());
        @(posedge clk);
        #1;
        step(i_idle(), o_idle(3'd0), "reset_state");
        rst = 1'b0;
        step(i_idle(), o_idle(3'd0), "after_reset");

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].i, vecs[k].o, vecs[k].name);
        end

        // multi-cycle op finishing after 10 wait cycles
        step(i_md(1, 0), o_idle(3'd0), "md_start");
        for (int k = 1; k <= 10; k++) begin
            step(i_md(0, k == 10), O_MD, "md_wait");
        end
        step(i_idle(), o_idle(3'd0), "md_done_exit");

        // jump abandons MD_WAIT on its third cycle
        step(i_md(1, 0), o_idle(3'd0), "md_start_2");
        step(i_idle(), O_MD, "md_wait_c1");
        step(i_idle(), O_MD, "md_wait_c2");
        step(i_jump(32'h80), o_jump(32'h80, 3'd2), "jump_in_md");
        step(i_idle(), O_FLUSH, "flush_after_md");
        step(i_idle(), o_idle(3'd0), "run_after_md_jump");

        // full halt handshake
        step(i_halt(), o_idle(3'd0), "halt_req");
        step(i_halt(), o_stall(3'd3, 0), "drain_c1");
        step(i_halt(), o_stall(3'd3, 0), "drain_c2");
        step(i_halt(), o_stall(3'd4, 0), "halt_enter");
        step(mk_in(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 1), o_stall(3'd4, 1), "halt_ignores_jump");
        step(i_idle(), o_stall(3'd4, 1), "halt_release");
        step(i_idle(), o_idle(3'd0), "run_after_halt");

        // request dropped mid-drain
        step(i_halt(), o_idle(3'd0), "halt_req_2");
        step(i_idle(), o_stall(3'd3, 0), "drain_drop");
        step(i_idle(), o_idle(3'd0), "drain_abort_run");

        // jump aborts drain, halt ignored through FLUSH
        step(i_halt(), o_idle(3'd0), "halt_req_3");
        step(mk_in(1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0, 1), o_jump(32'h400, 3'd3), "jump_in_drain");
        step(i_halt(), O_FLUSH, "halt_ignored_in_flush");
        step(i_halt(), o_idle(3'd0), "halt_req_rearm");
        step(i_idle(), o_stall(3'd3, 0), "drain_drop_2");
        step(i_idle(), o_idle(3'd0), "run_4");

        // timeout with no done
        step(i_md(1, 0), o_idle(3'd0), "md_start_to");
        for (int k = 1; k <= 64; k++) begin
            step(i_idle(), O_MD, "md_wait_to");
        end
        exp_to = 1'b1;
        step(i_idle(), o_idle(3'd0), "md_timeout_exit");
        step(i_idle(), o_idle(3'd0), "md_timeout_sticky");

        // async reset in the middle of DRAIN
        step(i_halt(), o_idle(3'd0), "halt_req_4");
        step(i_halt(), o_stall(3'd3, 0), "drain_before_rst");
        #2;
        rst = 1'b1;
        #1;
        exp_to = 1'b0;
        exp_q.push_back(o_idle(3'd0));
        nm_q.push_back("async_rst_mid_drain");
        check_one();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(i_idle(), o_idle(3'd0), "run_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
